fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register sitting directly upstream of the decoder. Holds the PC and issues word requests to instruction memory over a variable-latency req/valid handshake. Presents one instruction per cycle on `instr_o`/`pc_o`, with a NOP bubble whenever no valid instruction is available. Handles decode stalls through a one-entry skid buffer, and handles branch, exception and iret redirects, including discarding a stale in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_1000: first fetch address after reset.
- `EXC_VECTOR`, default 32'h0000_0100: redirect target on `exc_i`.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (addi x0,x0,0).
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rsn_i`  in  1  reset, synchronous, active-high.
- `stall_i`  in  1  decode stall; IF/ID register holds while high.
- `branch_i`  in  1  branch/jump redirect request.
- `branch_target_i`  in  32  branch target.
- `iret_i`  in  1  interrupt-return redirect.
- `iret_target_i`  in  32  saved return PC from CSR file.
- `exc_i`  in  1  exception redirect to `EXC_VECTOR`.
- `imem_req_o`  out  1  fetch request valid.
- `imem_addr_o`  out  32  fetch address, word-aligned.
- `imem_valid_i`  in  1  response valid for the outstanding request.
- `imem_rdata_i`  in  32  response instruction word.
- `instr_o`  out  32  IF/ID instruction, feeds decoder `instr_i`.
- `pc_o`  out  32  PC of `instr_o`.
- `valid_o`  out  1  `instr_o` is a real instruction (0 = bubble).

## Operation
- Registers: `pc_q`, state, skid buffer (instr+pc), IF/ID (`instr_o`, `pc_o`, `valid_o`), `drop_pc_q`.
- States:
  - REQ: request outstanding.
  - HOLD: a response is buffered and decode is stalled.
  - DROP: a redirect occurred while a request was in flight; the next response must be discarded.
- `imem_req_o` = (state==REQ or DROP) and !rsn_i.
- `imem_addr_o` = `pc_q`. It is stable while `imem_req_o`=1 and `imem_valid_i`=0.
- Redirect priority: exc_i > iret_i > branch_i. All targets have bits [1:0] forced to 0.
- REQ, no redirect, `imem_valid_i`=1:
  - If !stall_i: IF/ID ← {rdata, pc_q, 1}; `pc_q` += 4; stay in REQ.
  - If stall_i: skid ← {rdata, pc_q}; `pc_q` += 4; go to HOLD. IF/ID holds.
- REQ, `imem_valid_i`=0, !stall_i: IF/ID ← {NOP_INSTR, pc_q, 0}.
- HOLD: no request is issued. When !stall_i: IF/ID ← skid with valid=1; go to REQ.
- Redirect, any state, same cycle:
  - IF/ID ← {NOP_INSTR, target, 0}. This overrides stall_i.
  - Skid is invalidated.
- Redirect in REQ with `imem_valid_i`=0: `drop_pc_q` ← target; go to DROP.
- Redirect in REQ with `imem_valid_i`=1: the response is discarded; `pc_q` ← target; stay in REQ.
- Redirect in HOLD: `pc_q` ← target; go to REQ.
- Redirect in DROP: overwrites `drop_pc_q`.
- DROP with `imem_valid_i`=1: the response is discarded; `pc_q` ← `drop_pc_q`; go to REQ.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values (cycle after `rsn_i`=1 is sampled):
  - state=REQ, `pc_q`=RESET_PC, skid empty.
  - `instr_o`=NOP_INSTR, `pc_o`=RESET_PC, `valid_o`=0.
- `imem_req_o`=0 in any cycle where `rsn_i`=1. Reset asserted mid-request abandons the request; any response returned during reset is ignored.
- Fetch latency: a response at edge N appears on `instr_o` after edge N (1 cycle).
- Back-to-back: with zero-wait memory and no stall, throughput is one instruction per cycle.
- Redirect: the bubble is visible the cycle after the redirect. The target is requested the same cycle as the redirect-edge state update (from REQ/HOLD), or after the stale response (from DROP).
- At most one request is outstanding; memory must return responses in order.

## Test plan
- Reset then zero-wait memory returning `pc`: `instr_o` sequence 0x1000, 0x1004, 0x1008 with `valid_o`=1 from the 2nd cycle after reset release; `pc_o` matches.
- 3-cycle memory latency: `imem_addr_o` stays 0x1000 for 3 cycles; `valid_o`=0 with `instr_o`=0x00000013 on idle cycles.
- `stall_i` high for 4 cycles while a response for 0x1004 arrives: `instr_o` holds the 0x1000 word; 0x1004 appears on the cycle after stall drops; no word lost or duplicated.
- `branch_i` to 0x2002 with a request for 0x1008 in flight: the 0x1008 response is discarded; next request is 0x2000; IF/ID shows a bubble until 0x2000 data arrives.
- `exc_i`, `iret_i`(0x3000) and `branch_i` asserted together: next request is 0x0100; `valid_o`=0 the next cycle.
- `pc_q`=0xFFFFFFFC fetch completes: next `imem_addr_o`=0x00000000. Reset asserted mid-HOLD: outputs return to reset values in one cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Issues one word request at a time to instruction memory, buffers one response
// in a skid register while decode stalls, and steers exception/iret/branch
// redirects, discarding a stale in-flight response when needed.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_1000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0100,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rsn_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        iret_i,
   input  logic [31:0] iret_target_i,
   input  logic        exc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_drop_pc;
   logic [XLEN-1:0]   r_skid_instr;
   logic [XLEN-1:0]   r_skid_pc;
   logic [XLEN-1:0]   r_instr;
   logic [XLEN-1:0]   r_pc_out;
   logic              r_valid;

   logic              w_redir;
   logic [XLEN-1:0]   w_target;
   logic [XLEN-1:0]   w_pc_inc;
   logic [XLEN-1:0]   w_pc_nxt;
   logic [XLEN-1:0]   w_drop_pc_nxt;
   logic              w_skid_load;
   logic              w_ifid_load;
   logic [XLEN-1:0]   w_ifid_instr;
   logic [XLEN-1:0]   w_ifid_pc;
   logic              w_ifid_valid;

   // Redirect arbitration: exception beats iret beats branch; target word-aligned.
   always_comb begin
      w_redir  = exc_i | iret_i | branch_i;
      w_target = branch_target_i;
      if (iret_i) begin
         w_target = iret_target_i;
      end
      if (exc_i) begin
         w_target = EXC_VECTOR;
      end
      w_target[1:0] = 2'b00;
      w_pc_inc      = r_pc + XLEN'(4);
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rsn_i) begin
         r_state <= ST_REQ;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_REQ: begin
            if (w_redir && !imem_valid_i) begin
               w_state_nxt = ST_DROP;
            end else if (!w_redir && imem_valid_i && stall_i) begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (w_redir || !stall_i) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_DROP: begin
            if (imem_valid_i) begin
               w_state_nxt = ST_REQ;
            end
         end
         default: w_state_nxt = ST_REQ;
      endcase
   end

   // Output and datapath steering per state.
   always_comb begin
      imem_req_o    = ((r_state == ST_REQ) || (r_state == ST_DROP)) && !rsn_i;
      imem_addr_o   = r_pc;
      w_pc_nxt      = r_pc;
      w_drop_pc_nxt = r_drop_pc;
      w_skid_load   = 1'b0;
      w_ifid_load   = 1'b0;
      w_ifid_instr  = NOP_INSTR;
      w_ifid_pc     = r_pc;
      w_ifid_valid  = 1'b0;
      if (w_redir) begin
         // Bubble at the target overrides stall; any response this cycle is stale.
         w_ifid_load = 1'b1;
         w_ifid_pc   = w_target;
         case (r_state)
            ST_HOLD: w_pc_nxt = w_target;
            default: begin
               if (imem_valid_i) begin
                  w_pc_nxt = w_target;
               end else begin
                  w_drop_pc_nxt = w_target;
               end
            end
         endcase
      end else begin
         case (r_state)
            ST_REQ: begin
               if (imem_valid_i) begin
                  w_pc_nxt = w_pc_inc;
                  if (stall_i) begin
                     w_skid_load = 1'b1;
                  end else begin
                     w_ifid_load  = 1'b1;
                     w_ifid_instr = imem_rdata_i;
                     w_ifid_valid = 1'b1;
                  end
               end else if (!stall_i) begin
                  w_ifid_load = 1'b1;
               end
            end
            ST_HOLD: begin
               if (!stall_i) begin
                  w_ifid_load  = 1'b1;
                  w_ifid_instr = r_skid_instr;
                  w_ifid_pc    = r_skid_pc;
                  w_ifid_valid = 1'b1;
               end
            end
            ST_DROP: begin
               if (imem_valid_i) begin
                  w_pc_nxt = r_drop_pc;
               end
            end
            default: ;
         endcase
      end
   end

   // PC, skid buffer, drop target and IF/ID registers.
   always_ff @(posedge clk_i) begin
      if (rsn_i) begin
         r_pc         <= RESET_PC;
         r_drop_pc    <= RESET_PC;
         r_skid_instr <= NOP_INSTR;
         r_skid_pc    <= RESET_PC;
         r_instr      <= NOP_INSTR;
         r_pc_out     <= RESET_PC;
         r_valid      <= 1'b0;
      end else begin
         r_pc      <= w_pc_nxt;
         r_drop_pc <= w_drop_pc_nxt;
         if (w_skid_load) begin
            r_skid_instr <= imem_rdata_i;
            r_skid_pc    <= r_pc;
         end
         if (w_ifid_load) begin
            r_instr  <= w_ifid_instr;
            r_pc_out <= w_ifid_pc;
            r_valid  <= w_ifid_valid;
         end
      end
   end

   assign instr_o = r_instr;
   assign pc_o    = r_pc_out;
   assign valid_o = r_valid;

endmodule
